// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction field widths, the R-type word layout,
// opcode values shared with execute, and the fetch/decode FSM encoding.
package mips_pkg;

  localparam int unsigned WORD_SIZE_DEFAULT = 32;

  // Instruction field widths
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned SHAMT_W  = 5;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned JADDR_W  = 26;

  // Opcodes (instr[31:26])
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  // R-type layout, MSB first; I/J fields overlay its low bits
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [SHAMT_W-1:0]  shamt;
    logic [FUNCT_W-1:0]  funct;
  } rtype_word_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fd_state_e;

endpackage

// File: rtl/mips_fetch_decode_if.sv
// Bundle of fetch/decode stage signals: instruction-memory request/response,
// execute redirect, and the decoded-instruction handshake with its fields.
// master = fetch/decode stage, slave = memory + execute side.
interface mips_fetch_decode_if #(parameter int unsigned WORD_SIZE = 32);

  logic                 imem_req_valid;
  logic                 imem_req_ready;
  logic [WORD_SIZE-1:0] imem_req_addr;
  logic                 imem_rsp_valid;
  logic [WORD_SIZE-1:0] imem_rsp_data;
  logic                 redirect_valid;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic                 dec_valid;
  logic                 dec_ready;
  logic [WORD_SIZE-1:0] dec_pc;
  logic [5:0]           opcode;
  logic [4:0]           rtype_rs;
  logic [4:0]           itype_rs;
  logic [4:0]           rtype_rt;
  logic [4:0]           itype_rt;
  logic [4:0]           rtype_rd;
  logic [4:0]           rtype_shamt;
  logic [5:0]           rtype_funct;
  logic [15:0]          itype_immediate;
  logic [25:0]          jtype_addres;
  logic [31:0]          stall_count;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output dec_valid, dec_pc,
    input  dec_ready,
    output opcode, rtype_rs, itype_rs, rtype_rt, itype_rt, rtype_rd,
    output rtype_shamt, rtype_funct, itype_immediate, jtype_addres,
    output stall_count
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  dec_valid, dec_pc,
    output dec_ready,
    input  opcode, rtype_rs, itype_rs, rtype_rt, itype_rt, rtype_rd,
    input  rtype_shamt, rtype_funct, itype_immediate, jtype_addres,
    input  stall_count
  );

endinterface

// File: rtl/mips_field_split.sv
// Combinational split of a 32-bit MIPS word into R/I/J fields.
// Ports: instr in; opcode, rs, rt, rd, shamt, funct, immediate, jaddr out.
// Pure bit slices; any immediate extension is left to the consumer.
module mips_field_split
  import mips_pkg::*;
(
  input  logic [31:0]         instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [REG_W-1:0]    rs,
  output logic [REG_W-1:0]    rt,
  output logic [REG_W-1:0]    rd,
  output logic [SHAMT_W-1:0]  shamt,
  output logic [FUNCT_W-1:0]  funct,
  output logic [IMM_W-1:0]    immediate,
  output logic [JADDR_W-1:0]  jaddr
);

  rtype_word_t word;

  assign word      = rtype_word_t'(instr);
  assign opcode    = word.opcode;
  assign rs        = word.rs;
  assign rt        = word.rt;
  assign rd        = word.rd;
  assign shamt     = word.shamt;
  assign funct     = word.funct;
  assign immediate = instr[IMM_W-1:0];
  assign jaddr     = instr[JADDR_W-1:0];

endmodule

// File: rtl/mips_fetch_decode.sv
// MIPS fetch and field-split stage: owns the PC, issues one instruction
// fetch at a time, registers the returned word and presents it split into
// fields over a valid/ready handshake. Execute redirects reload the PC and
// cancel any fetch already in flight.
// Ports: clk, rst_n (async, active-low); bus (mips_fetch_decode_if.master)
// carrying imem req/rsp, redirect, dec handshake, fields and stall_count.
// Optional: MIPS_FD_STALL_COUNT_EN builds the backpressure cycle counter;
// otherwise stall_count is tied to 0.
module mips_fetch_decode
  import mips_pkg::*;
#(
  parameter int unsigned          WORD_SIZE = WORD_SIZE_DEFAULT,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input logic                clk,
  input logic                rst_n,
  mips_fetch_decode_if.master bus
);

  fd_state_e            state, state_next;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] instr_q, instr_d;
  logic [WORD_SIZE-1:0] dec_pc_q, dec_pc_d;
  logic                 drop_q, drop_d;
  logic                 req_valid_q;
  logic                 dec_valid_q;
  logic                 req_fire;
  logic [WORD_SIZE-1:0] redirect_target;

  assign req_fire        = req_valid_q & bus.imem_req_ready;
  assign redirect_target = {bus.redirect_pc[WORD_SIZE-1:2], 2'b00};

  // Next-state and datapath update
  always_comb begin
    state_next = state;
    pc_d       = pc_q;
    instr_d    = instr_q;
    dec_pc_d   = dec_pc_q;
    drop_d     = drop_q;

    case (state)
      ST_FETCH: begin
        if (req_fire) begin
          state_next = ST_WAIT;
          // Redirect alongside an accepted request: the old-pc fetch is stale
          drop_d     = bus.redirect_valid;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (drop_q || bus.redirect_valid) begin
            state_next = ST_FETCH;
            drop_d     = 1'b0;
          end else begin
            state_next = ST_HOLD;
            instr_d    = bus.imem_rsp_data;
            dec_pc_d   = pc_q;
            pc_d       = pc_q + WORD_SIZE'(4);
          end
        end else if (bus.redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.redirect_valid || bus.dec_ready) begin
          state_next = ST_FETCH;
        end
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase

    if (bus.redirect_valid) begin
      pc_d = redirect_target;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and registered handshake flags (mirror next state so the
  // request stays low for the first cycle out of reset)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      dec_pc_q    <= '0;
      drop_q      <= 1'b0;
      req_valid_q <= 1'b0;
      dec_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      dec_pc_q    <= dec_pc_d;
      drop_q      <= drop_d;
      req_valid_q <= (state_next == ST_FETCH);
      dec_valid_q <= (state_next == ST_HOLD);
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc_q;
  assign bus.dec_valid      = dec_valid_q;
  assign bus.dec_pc         = dec_pc_q;

  logic [REG_W-1:0] rs, rt;

  mips_field_split u_field_split (
    .instr     (instr_q),
    .opcode    (bus.opcode),
    .rs        (rs),
    .rt        (rt),
    .rd        (bus.rtype_rd),
    .shamt     (bus.rtype_shamt),
    .funct     (bus.rtype_funct),
    .immediate (bus.itype_immediate),
    .jaddr     (bus.jtype_addres)
  );

  assign bus.rtype_rs = rs;
  assign bus.itype_rs = rs;
  assign bus.rtype_rt = rt;
  assign bus.itype_rt = rt;

`ifdef MIPS_FD_STALL_COUNT_EN
  logic [31:0] stall_count_q;

  // Cycles the presented instruction waits on execute
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else if (dec_valid_q && !bus.dec_ready) begin
      stall_count_q <= stall_count_q + 32'(1);
    end
  end

  assign bus.stall_count = stall_count_q;
`else
  assign bus.stall_count = '0;
`endif

endmodule
